// File: rtl/calc_datapath.sv
// calc_datapath: operand/result datapath for the calculator control unit.
// Captures switch data into A/B, runs add/sub in one cycle or mul/div iteratively,
// and holds the result for the display stage.
// Optional feature macro: CALC_DIV_EN (restoring divider for op 11). When undefined,
// op 11 reports err with a zero result.
//
// state  | meaning
// S_IDLE | waiting for a start edge or a load strobe
// S_CALC | operation running, busy=1
// S_DONE | result valid, done=1 until start, load strobe or clear

module calc_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_input,
  input  logic [3:0]         control,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [1:0]         op_sel,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               neg,
  output logic               err
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a, r_b, r_opa, r_opb, r_mplier;
  logic [1:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand, r_result;
  logic               r_ctrl3_q, r_busy, r_done, r_neg, r_err;

  logic               w_start, w_last, w_finish, w_a_ge_b;
  logic [2*WIDTH-1:0] w_add, w_mul_next;
  logic [WIDTH-1:0]   w_sub;

`ifdef CALC_DIV_EN
  logic [WIDTH:0]     w_shift, w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;

  // One restoring-division step on {remainder, dividend/quotient} held in r_acc
  always_comb begin
    w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_opb});
    w_diff     = w_shift - {1'b0, r_opb};
    w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
  end
`endif

  // Start edge, single-cycle results, multiply step and end-of-operation decode
  always_comb begin
    w_start    = control[3] && !r_ctrl3_q && (r_state != S_CALC);
    w_last     = (r_cnt == CW'(WIDTH - 1));
    w_add      = {{WIDTH{1'b0}}, r_opa} + {{WIDTH{1'b0}}, r_opb};
    w_a_ge_b   = (r_opa >= r_opb);
    w_sub      = w_a_ge_b ? (r_opa - r_opb) : (r_opb - r_opa);
    w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_finish   = 1'b0;
    if (r_state == S_CALC) begin
      case (r_op)
        2'b00, 2'b01: w_finish = 1'b1;
        2'b10:        w_finish = w_last;
`ifdef CALC_DIV_EN
        default:      w_finish = (r_opb == '0) || w_last;
`else
        default:      w_finish = 1'b1;
`endif
      endcase
    end
  end

  // Control FSM with operand capture, iteration and registered outputs
  always_ff @(posedge clk) begin
    if (reset || clear_input) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_mplier  <= '0;
      r_op      <= 2'b00;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_result  <= '0;
      r_ctrl3_q <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_neg     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ctrl3_q <= control[3];
      case (r_state)
        S_CALC: begin
          case (r_op)
            2'b00: r_result <= w_add;
            2'b01: begin
              r_result <= {{WIDTH{1'b0}}, w_sub};
              r_neg    <= !w_a_ge_b;
            end
            2'b10: begin
              r_acc    <= w_mul_next;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
              r_cnt    <= r_cnt + 1'b1;
              if (w_last) r_result <= w_mul_next;
            end
            default: begin
`ifdef CALC_DIV_EN
              if (r_opb == '0) begin
                r_result <= '0;
                r_err    <= 1'b1;
              end else begin
                r_acc <= w_div_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) r_result <= w_div_next;
              end
`else
              r_result <= '0;
              r_err    <= 1'b1;
`endif
            end
          endcase
          if (w_finish) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (w_start) begin
            r_opa    <= r_a;
            r_opb    <= r_b;
            r_op     <= op_sel;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, r_a};
            r_mplier <= r_b;
            // divide seeds the dividend into the low half; multiply accumulates from zero
            r_acc    <= (op_sel == 2'b11) ? {{WIDTH{1'b0}}, r_a} : '0;
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
          end else if (control[1]) begin
            if (control[0])      r_a <= data_in;
            else if (control[2]) r_b <= data_in;
            r_done <= 1'b0;
            r_neg  <= 1'b0;
            r_err  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign neg    = r_neg;
  assign err    = r_err;

endmodule

// File: tb/tb_calc_datapath.sv
// Scoreboard bench for calc_datapath (WIDTH=8): stimulus pushes hand-computed expected
// responses, a monitor pops and compares whenever done rises.

module tb_calc_datapath;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset, clear_input;
  logic [3:0]     control;
  logic [W-1:0]   data_in;
  logic [1:0]     op_sel;
  logic [2*W-1:0] result;
  logic           busy, done, neg, err;

  typedef struct {
    logic [2*W-1:0] res;
    logic           neg;
    logic           err;
    int             lat;
    int             start;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  calc_datapath #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clear_input(clear_input), .control(control),
    .data_in(data_in), .op_sel(op_sel), .result(result), .busy(busy),
    .done(done), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic is_a, input logic [W-1:0] v);
    control = is_a ? 4'b0011 : 4'b0110;
    data_in = v;
    tick();
    control = 4'b0000;
    tick();
  endtask

  task automatic start(input logic [1:0] op, input logic [2*W-1:0] r,
                       input logic n, input logic e, input int lat, input logic push);
    exp_t x;
    op_sel  = op;
    control = 4'b1000;
    if (push) begin
      x.res = r; x.neg = n; x.err = e; x.lat = lat; x.start = cyc;
      q.push_back(x);
    end
    tick();
    control = 4'b0000;
  endtask

  task automatic wait_done(output int nbusy);
    bit seen;
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
      tick();
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: done not seen within 40 cycles, got 0 expected 1");
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                     input logic [2*W-1:0] r, input logic n, input logic e, input int lat);
    int nb;
    load(1'b1, a);
    load(1'b0, b);
    start(op, r, n, e, lat, 1'b1);
    wait_done(nb);
    check("busy_cycles", nb, lat - 1);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
    check({tag, "_result"}, result, 0);
    check({tag, "_neg"},    neg,    0);
    check({tag, "_err"},    err,    0);
  endtask

  // Monitor: compare each completed operation against the scoreboard
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      check("busy_and_done_exclusive", {31'd0, busy & done}, 0);
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got result %0d with empty scoreboard", result);
        end else begin
          x = q.pop_front();
          check("result",  result, x.res);
          check("neg",     neg,    x.neg);
          check("err",     err,    x.err);
          check("latency", cyc - x.start, x.lat);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    int nb;
    reset = 1'b1; clear_input = 1'b0; control = 4'b0000; data_in = '0; op_sel = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    check_zero("reset");
    tick();

    run(8'd200, 8'd100, 2'b00, 16'd300, 1'b0, 1'b0, 2);
    run(8'd255, 8'd255, 2'b00, 16'd510, 1'b0, 1'b0, 2);
    run(8'd5,   8'd9,   2'b01, 16'd4,   1'b1, 1'b0, 2);
    load(1'b1, 8'd5);
    check("strobe_clears_done", done, 0);
    check("strobe_clears_neg",  neg,  0);
    run(8'd9,   8'd5,   2'b01, 16'd4,   1'b0, 1'b0, 2);
    run(8'd7,   8'd7,   2'b01, 16'd0,   1'b0, 1'b0, 2);
    run(8'd255, 8'd255, 2'b10, 16'd65025, 1'b0, 1'b0, 9);
`ifdef CALC_DIV_EN
    run(8'd100, 8'd7,  2'b11, {8'd2, 8'd14},  1'b0, 1'b0, 9);
    run(8'd255, 8'd16, 2'b11, {8'd15, 8'd15}, 1'b0, 1'b0, 9);
`else
    run(8'd100, 8'd7,  2'b11, 16'd0, 1'b0, 1'b1, 2);
`endif
    run(8'd100, 8'd0,  2'b11, 16'd0, 1'b0, 1'b1, 2);
    run(8'd13,  8'd11, 2'b10, 16'd143, 1'b0, 1'b0, 9);

    // clear_input at cycle t+4 of a multiply
    load(1'b1, 8'd3);
    load(1'b0, 8'd4);
    start(2'b10, '0, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) tick();
    check("mid_calc_busy",        busy,   1);
    check("mid_calc_result_held", result, 143);
    clear_input = 1'b1;
    tick();
    clear_input = 1'b0;
    check_zero("clear_abort");
    start(2'b00, 16'd0, 1'b0, 1'b0, 2, 1'b1);
    wait_done(nb);
    tick();

    // operand strobe during a multiply must not disturb it nor land in B
    load(1'b1, 8'd2);
    load(1'b0, 8'd4);
    start(2'b10, 16'd8, 1'b0, 1'b0, 9, 1'b1);
    tick();
    control = 4'b0110;
    data_in = 8'd3;
    tick();
    control = 4'b0000;
    wait_done(nb);
    tick();
    start(2'b00, 16'd6, 1'b0, 1'b0, 2, 1'b1);
    wait_done(nb);
    tick();

    // reset at cycle t+4 of a multiply
    start(2'b10, '0, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) tick();
    check("mid_calc_busy_2", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("reset_abort");
    start(2'b00, 16'd0, 1'b0, 1'b0, 2, 1'b1);
    wait_done(nb);
    repeat (2) tick();

    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
